// File: rtl/if_stage_pkg.sv
// ============================================================================
//  Module   : if_stage_pkg
//  Purpose  : Shared definitions for the instruction-fetch stage: reset and
//             bus constants, RV32I opcodes used by static prediction, and the
//             fetch-state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam logic        RstEnable        = 1'b1;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam int          STALL_W_DEFAULT  = 6;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;

  // FETCH: request outstanding for the current pc.
  // VALID: buffered instruction presented downstream.
  // DROP : an un-abortable request is still in flight after a redirect; its
  //        data must be discarded before fetching the new pc.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DROP  = 2'd2
  } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_predecode.sv
// ============================================================================
//  Module   : if_predecode
//  Purpose  : Combinational static predictor. JAL and backward conditional
//             branches are predicted taken; everything else falls through.
//  Ports    : inst    - instruction word being presented
//             pc      - address of that instruction
//             taken   - prediction for the instruction
//             next_pc - address to fetch next
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_predecode
  import if_stage_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        taken,
  output logic [31:0] next_pc
);

  logic [31:0] w_imm_j;
  logic [31:0] w_imm_b;

  assign w_imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign w_imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

  always_comb begin
    taken   = 1'b0;
    next_pc = pc + 32'd4;
    if (inst[6:0] == OPC_JAL) begin
      taken   = 1'b1;
      next_pc = pc + w_imm_j;
    end else if ((inst[6:0] == OPC_BRANCH) && inst[31]) begin
      // Sign bit set means a backward branch: the usual loop-closing case.
      taken   = 1'b1;
      next_pc = pc + w_imm_b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  Module   : if_stage
//  Purpose  : RV32I instruction-fetch stage. Owns the PC, fetches one word
//             per request from the memory controller, statically predicts
//             JAL / backward branches, and handles EX redirects.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             stall_sign          - hold request from ctrl (bit0 = hold IF)
//             stallreq_if         - stall request to ctrl while no inst valid
//             ex_branch_flag/
//             ex_branch_target    - single-cycle redirect from EX
//             mem_req_o/mem_addr_o- fetch request / word-aligned address
//             mem_ready_i/
//             mem_data_i          - one-cycle response pulse and data
//             if_pc/if_inst/
//             if_taken            - presented instruction to IF/ID
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          STALL_W  = STALL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_sign,
  output logic               stallreq_if,
  input  logic               ex_branch_flag,
  input  logic [31:0]        ex_branch_target,
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  input  logic               mem_ready_i,
  input  logic [31:0]        mem_data_i,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic               if_taken
);

  if_state_e   r_state,      w_state_nxt;
  logic [31:0] r_pc,         w_pc_nxt;
  logic [31:0] r_fetch_addr, w_fetch_addr_nxt;
  logic [31:0] r_inst_buf,   w_inst_buf_nxt;

  logic        w_taken;
  logic [31:0] w_next_pc;

  // Only bit0 of the stall bus concerns this stage.
  logic        w_stall_unused;
  assign w_stall_unused = &{1'b0, stall_sign[STALL_W-1:1]};

  if_predecode u_predecode (
    .inst    (r_inst_buf),
    .pc      (r_pc),
    .taken   (w_taken),
    .next_pc (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_inst_buf   <= ZeroWord;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_inst_buf   <= w_inst_buf_nxt;
    end
  end

  // Next-state logic. A redirect outranks both stall and normal advance.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fetch_addr_nxt = r_fetch_addr;
    w_inst_buf_nxt   = r_inst_buf;
    case (r_state)
      S_FETCH: begin
        if (ex_branch_flag) begin
          w_pc_nxt = ex_branch_target;
          if (mem_ready_i) begin
            // Response arrived with the redirect: drop it, refetch at once.
            w_fetch_addr_nxt = ex_branch_target;
          end else begin
            // Request cannot be withdrawn; wait for it and discard the data.
            w_state_nxt = S_DROP;
          end
        end else if (mem_ready_i) begin
          w_inst_buf_nxt = mem_data_i;
          w_state_nxt    = S_VALID;
        end
      end
      S_VALID: begin
        if (ex_branch_flag) begin
          w_pc_nxt         = ex_branch_target;
          w_fetch_addr_nxt = ex_branch_target;
          w_state_nxt      = S_FETCH;
        end else if (!stall_sign[0]) begin
          w_pc_nxt         = w_next_pc;
          w_fetch_addr_nxt = w_next_pc;
          w_state_nxt      = S_FETCH;
        end
      end
      S_DROP: begin
        if (ex_branch_flag) begin
          w_pc_nxt = ex_branch_target;
        end
        if (mem_ready_i) begin
          // pc already holds the latest target, including one arriving now.
          w_fetch_addr_nxt = ex_branch_flag ? ex_branch_target : r_pc;
          w_state_nxt      = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Outputs are forced quiet during the reset cycle itself.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = ZeroWord;
    stallreq_if = 1'b0;
    if_pc       = ZeroWord;
    if_inst     = ZeroWord;
    if_taken    = 1'b0;
    if (rst != RstEnable) begin
      mem_addr_o = {r_fetch_addr[31:2], 2'b00};
      if_pc      = r_pc;
      case (r_state)
        S_VALID: begin
          if_inst  = r_inst_buf;
          if_taken = w_taken;
        end
        default: begin
          mem_req_o   = 1'b1;
          stallreq_if = 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage. The stimulus process plays the
//             memory controller, EX and ctrl, and pushes expected fetch
//             addresses and presented instructions into queues; a monitor
//             process pops and compares whenever the DUT starts a request or
//             presents an instruction.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          STALL_W  = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall_sign;
  logic               stallreq_if;
  logic               ex_branch_flag;
  logic [31:0]        ex_branch_target;
  logic               mem_req_o;
  logic [31:0]        mem_addr_o;
  logic               mem_ready_i;
  logic [31:0]        mem_data_i;
  logic [31:0]        if_pc;
  logic [31:0]        if_inst;
  logic               if_taken;

  if_stage #(.RESET_PC(RESET_PC), .STALL_W(STALL_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_sign       (stall_sign),
    .stallreq_if      (stallreq_if),
    .ex_branch_flag   (ex_branch_flag),
    .ex_branch_target (ex_branch_target),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ready_i      (mem_ready_i),
    .mem_data_i       (mem_data_i),
    .if_pc            (if_pc),
    .if_inst          (if_inst),
    .if_taken         (if_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
  } pres_t;

  logic [31:0] exp_addr_q[$];
  pres_t       exp_pres_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: where control goes after this instruction.
  function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                  output logic taken, output logic [31:0] nxt);
    int off;
    taken = 1'b0;
    off   = 4;
    if (inst[6:0] == 7'h6F) begin
      taken = 1'b1;
      off = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096
          + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
    end else if (inst[6:0] == 7'h63 && inst[31]) begin
      taken = 1'b1;
      off = -4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
    end
    nxt = pc + off;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    int          cls;
    r   = $urandom;
    cls = $urandom_range(0, 4);
    case (cls)
      0:       gen_inst = {r[31:7], 7'h6F};
      1:       gen_inst = {1'b1, r[30:7], 7'h63};
      2:       gen_inst = {1'b0, r[30:7], 7'h63};
      3:       gen_inst = {r[31:7], 7'h67};
      default: gen_inst = {r[31:7], 7'h13};
    endcase
  endfunction

  task automatic push_addr(input logic [31:0] a);
    exp_addr_q.push_back({a[31:2], 2'b00});
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic  prev_req   = 1'b0;
    logic  prev_valid = 1'b0;
    logic  valid;
    pres_t p;
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #1;
      valid = !rst && !stallreq_if;
      if (mem_req_o && (!prev_req || mem_ready_i)) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: addr %h, nothing expected", mem_addr_o);
        end else begin
          a = exp_addr_q.pop_front();
          check("req_addr", mem_addr_o, a);
        end
      end
      if (valid && !prev_valid) begin
        if (exp_pres_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_present: pc %h inst %h, nothing expected", if_pc, if_inst);
        end else begin
          p = exp_pres_q.pop_front();
          check("if_pc", if_pc, p.pc);
          check("if_inst", if_inst, p.inst);
          check("if_taken", {31'b0, if_taken}, {31'b0, p.taken});
        end
      end
      prev_req   = mem_req_o;
      prev_valid = valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs();
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_stallreq", {31'b0, stallreq_if}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_if_taken", {31'b0, if_taken}, 32'd0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req_o) begin
      $display("FAIL req_timeout: mem_req_o stuck at 0");
      n_checks++;
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "request timeout");
    end
  endtask

  // kind: 0 advance, 1 redirect in VALID, 2 redirect with ready,
  //       3 redirect while waiting (DROP), 4 reset in FETCH, 5 reset in VALID
  task automatic do_txn(input int kind, input logic [31:0] inst, input int lat,
                        input int stall_cyc, input logic [31:0] tgt, input logic [31:0] tgt2);
    logic        tk;
    logic [31:0] nxt;
    wait_req();
    for (int i = 0; i < lat; i++) begin
      mem_ready_i = 1'b0;
      @(negedge clk);
      check("wait_stallreq", {31'b0, stallreq_if}, 32'd1);
    end
    if (kind == 4) begin
      rst = 1'b1;
      model_pc = RESET_PC;
      push_addr(RESET_PC);
      @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      return;
    end
    if (kind == 3) begin
      ex_branch_flag   = 1'b1;
      ex_branch_target = tgt;
      model_pc         = tgt;
      @(negedge clk);
      ex_branch_flag = 1'b0;
      check("drop_pc", if_pc, model_pc);
      check("drop_inst", if_inst, 32'd0);
      check("drop_stallreq", {31'b0, stallreq_if}, 32'd1);
      if (tgt2 != 32'd0) begin
        ex_branch_flag   = 1'b1;
        ex_branch_target = tgt2;
        model_pc         = tgt2;
      end
      mem_ready_i = 1'b1;
      mem_data_i  = inst;
      push_addr(model_pc);
      @(negedge clk);
      mem_ready_i    = 1'b0;
      ex_branch_flag = 1'b0;
      return;
    end
    if (kind == 2) begin
      mem_ready_i      = 1'b1;
      mem_data_i       = inst;
      ex_branch_flag   = 1'b1;
      ex_branch_target = tgt;
      model_pc         = tgt;
      push_addr(model_pc);
      @(negedge clk);
      mem_ready_i    = 1'b0;
      ex_branch_flag = 1'b0;
      check("redir_ready_stallreq", {31'b0, stallreq_if}, 32'd1);
      return;
    end
    predict(inst, model_pc, tk, nxt);
    mem_ready_i = 1'b1;
    mem_data_i  = inst;
    exp_pres_q.push_back('{pc: model_pc, inst: inst, taken: tk});
    @(negedge clk);
    mem_ready_i = 1'b0;
    check("present_latency", {31'b0, stallreq_if}, 32'd0);
    if (kind == 5) begin
      rst = 1'b1;
      model_pc = RESET_PC;
      push_addr(RESET_PC);
      @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      return;
    end
    for (int i = 0; i < stall_cyc; i++) begin
      stall_sign = 6'b000001;
      @(negedge clk);
      check("stall_inst", if_inst, inst);
      check("stall_pc", if_pc, model_pc);
      check("stall_req", {31'b0, mem_req_o}, 32'd0);
    end
    stall_sign = '0;
    if (kind == 1) begin
      ex_branch_flag   = 1'b1;
      ex_branch_target = tgt;
      model_pc         = tgt;
    end else begin
      model_pc = nxt;
    end
    push_addr(model_pc);
    @(negedge clk);
    ex_branch_flag = 1'b0;
    check("next_req_rise", {31'b0, mem_req_o}, 32'd1);
  endtask

  initial begin : stimulus
    int          kind;
    int          r;
    logic [31:0] t1;
    logic [31:0] t2;
    rst              = 1'b1;
    stall_sign       = '0;
    ex_branch_flag   = 1'b0;
    ex_branch_target = '0;
    mem_ready_i      = 1'b0;
    mem_data_i       = '0;
    model_pc         = RESET_PC;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    push_addr(RESET_PC);
    rst = 1'b0;

    // Directed walk through the key scenarios.
    do_txn(0, 32'h0000_0013, 3, 0, 0, 0);           // pc 0  -> 4
    do_txn(0, 32'h0080_006F, 1, 0, 0, 0);           // jal +8 -> C
    do_txn(0, 32'h0000_0013, 0, 0, 0, 0);           // C -> 10
    do_txn(0, 32'hFE00_0EE3, 2, 0, 0, 0);           // beq -4 -> C
    do_txn(0, 32'h0000_0013, 0, 0, 0, 0);           // C -> 10
    do_txn(0, 32'h0000_0463, 1, 2, 0, 0);           // beq +8 not taken, stalled -> 14
    do_txn(1, 32'h0000_0013, 0, 0, 32'h8, 0);       // redirect to 8
    do_txn(3, 32'hDEAD_BEEF, 2, 0, 32'h100, 0);     // redirect while waiting on 8
    do_txn(1, 32'h0000_0013, 1, 0, 32'h8, 0);
    do_txn(2, 32'hDEAD_BEEF, 1, 0, 32'h100, 0);     // redirect coinciding with ready
    do_txn(4, 32'h0, 1, 0, 0, 0);                   // reset mid-fetch
    do_txn(5, 32'h0000_0013, 0, 0, 0, 0);           // reset in VALID

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 55) kind = 0;
      else if (r < 67) kind = 1;
      else if (r < 77) kind = 2;
      else if (r < 92) kind = 3;
      else if (r < 96) kind = 4;
      else             kind = 5;
      t1 = $urandom & 32'hFFFF_FFFC;
      t2 = ($urandom_range(0, 1) == 1) ? ($urandom | 32'h4) & 32'hFFFF_FFFC : 32'd0;
      do_txn(kind, gen_inst(), $urandom_range(0, 4), $urandom_range(0, 2), t1, t2);
    end

    repeat (3) @(negedge clk);
    check("addr_q_drained", exp_addr_q.size(), 32'd0);
    check("pres_q_drained", exp_pres_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the PC, fetches one 32-bit instruction per request from the memory controller over a req/ready handshake, and statically predicts JAL and backward branches. It drives if_pc/if_inst/if_taken into IF/ID and raises a stall request to ctrl while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
STALL_W, 6, width of stall_sign bus (StallBus)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high (RstEnable)
stall_sign  in  STALL_W  from ctrl; bit0 = hold PC/IF
stallreq_if  out  1  to ctrl; 1 while no valid instruction is presented
ex_branch_flag  in  1  mispredict/redirect from EX, single-cycle pulse
ex_branch_target  in  32  redirect PC
mem_req_o  out  1  fetch request to memory controller
mem_addr_o  out  32  fetch address, word-aligned
mem_ready_i  in  1  one-cycle pulse, mem_data_i valid
mem_data_i  in  32  fetched instruction word
if_pc  out  32  PC of presented instruction
if_inst  out  32  presented instruction (0 when invalid)
if_taken  out  1  prediction taken for presented instruction

Behaviour:
- Registers: pc, fetch_addr, inst_buf, state ∈ {FETCH, VALID, DROP}.
- Reset (synchronous, wins over everything): pc = fetch_addr = RESET_PC, inst_buf = 0, state = FETCH. mem_req_o = 0 during the reset cycle. if_pc = 0, if_inst = 0, if_taken = 0, stallreq_if = 0 during reset. Reset mid-fetch abandons the request; the controller must tolerate req dropping.
- FETCH:
  - Outputs: mem_req_o = 1, mem_addr_o = fetch_addr held stable, stallreq_if = 1, if_inst = 0, if_taken = 0, if_pc = pc.
  - On mem_ready_i: inst_buf <= mem_data_i, go to VALID.
- VALID:
  - Outputs: mem_req_o = 0, stallreq_if = 0, if_inst = inst_buf, if_pc = pc, if_taken = prediction.
  - If stall_sign[0] = 0 at the clock edge: pc <= next_pc, fetch_addr <= next_pc, go to FETCH.
  - If stall_sign[0] = 1: hold all state and outputs.
- Prediction (combinational on inst_buf and pc):
  - opcode 1101111 (JAL): taken = 1, next_pc = pc + immJ.
  - opcode 1100011 with inst[31] = 1 (negative immB): taken = 1, next_pc = pc + immB.
  - Otherwise: taken = 0, next_pc = pc + 4.
  - All adds are 32-bit modulo; wrap ignored. JALR is never predicted.
- Redirect (ex_branch_flag = 1) has priority over stall and normal advance:
  - VALID: pc <= fetch_addr <= target, go to FETCH, buffered instruction discarded.
  - FETCH with mem_ready_i in the same cycle: data dropped, pc <= fetch_addr <= target, stay in FETCH.
  - FETCH without ready: pc <= target, go to DROP. The request cannot be aborted.
  - DROP: mem_req_o = 1 on the old fetch_addr, stallreq_if = 1, outputs as in FETCH with if_pc = pc. On ready: data discarded, fetch_addr <= pc, go to FETCH.
  - A further redirect while in DROP only overwrites pc.
- Latency: with mem_ready_i arriving N cycles after req rises, the instruction is presented in the cycle after ready, and the next req rises one cycle after that if not stalled.
- mem_addr_o[1:0] are always 0. Targets are taken as given; misalignment is EX's responsibility.

Decomposition:
- Shared defines file (alongside RstEnable/ZeroWord/StallBus): OPC_JAL, OPC_BRANCH, RESET_PC default, IF state encodings.
- Sub-module if_predecode (combinational): inputs inst, pc; outputs taken, next_pc. Contains the immJ/immB extraction.
- if_stage holds the FSM, PC and buffer.

Test Plan:
1. Reset, then mem_ready_i 3 cycles after req with 32'h00000013 -> mem_addr_o = 0, stallreq_if = 1 throughout the wait; then if_pc = 0, if_inst = 32'h13, if_taken = 0; next req addr = 4.
2. At pc 4 return 32'h0080006F (jal x0,8) -> if_taken = 1; next mem_addr_o = 32'hC.
3. At pc 32'h10 return 32'hFE000EE3 (beq -4) -> taken = 1, next addr 32'hC. Return 32'h00000463 (beq +8) -> taken = 0, next addr 32'h14.
4. In VALID, hold stall_sign[0] = 1 for 2 cycles -> if_* held, mem_req_o = 0, pc unchanged; release -> req to next_pc the following cycle.
5. Pulse ex_branch_flag with target 32'h100 while waiting on addr 32'h8 -> req stays on 32'h8 until ready, data not presented, then req on 32'h100. Repeat with the redirect coinciding with ready -> next req is 32'h100 immediately.
6. Assert rst mid-FETCH and in VALID -> next cycle all outputs 0, then req on RESET_PC.
